// File: rtl/udp_reg_counter_node_pkg.sv
// Shared widths, constants and address-split helpers for the counter node on the UDP register ring.
package udp_reg_counter_node_pkg;

  localparam int UDP_REG_ADDR_WIDTH  = 23;
  localparam int CPCI_NF2_DATA_WIDTH = 32;

  localparam logic [CPCI_NF2_DATA_WIDTH-1:0] DEFAULT_UNDECODED_RESULT = 32'hdead_beef;

  typedef enum logic [1:0] {
    ACT_IDLE,
    ACT_FORWARD,
    ACT_CLAIM
  } node_action_e;

  // Tag sits in the top tag_width bits of the word address.
  function automatic logic [UDP_REG_ADDR_WIDTH-1:0] addr_tag(
    input logic [UDP_REG_ADDR_WIDTH-1:0] addr,
    input int                            tag_width
  );
    return addr >> (UDP_REG_ADDR_WIDTH - tag_width);
  endfunction

  // In-block index occupies the low idx_width bits.
  function automatic logic [UDP_REG_ADDR_WIDTH-1:0] addr_index(
    input logic [UDP_REG_ADDR_WIDTH-1:0] addr,
    input int                            idx_width
  );
    return addr & ((UDP_REG_ADDR_WIDTH'(1) << idx_width) - UDP_REG_ADDR_WIDTH'(1));
  endfunction

endpackage

// File: rtl/udp_reg_event_counter.sv
// Single 32-bit wrapping event counter with software load and clear-on-read.
module udp_reg_event_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        load,
  input  logic [31:0] load_value,
  input  logic        rd_clear,
  output logic [31:0] count
);

  logic [31:0] count_reg;
  logic [31:0] count_next;

  // A load beats a same-cycle increment; a clearing read keeps that cycle's event.
  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_value;
    end else if (rd_clear) begin
      count_next = {31'd0, inc};
    end else if (inc) begin
      count_next = count_reg + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/udp_reg_counter_node.sv
// Register-ring slave: claims in-tag accesses to event counters and software registers, forwards everything else.
module udp_reg_counter_node
  import udp_reg_counter_node_pkg::*;
#(
  parameter int                             TAG               = 0,
  parameter int                             TAG_WIDTH         = 17,
  parameter int                             REG_ADDR_WIDTH    = 6,
  parameter int                             NUM_COUNTERS      = 4,
  parameter int                             NUM_SW            = 2,
  parameter bit                             RESET_ON_READ     = 1'b0,
  parameter int                             UDP_REG_SRC_WIDTH = 2,
  parameter logic [CPCI_NF2_DATA_WIDTH-1:0] UNDECODED_RESULT  = DEFAULT_UNDECODED_RESULT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           reg_req_in,
  input  logic                           reg_ack_in,
  input  logic                           reg_rd_wr_L_in,
  input  logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in,
  input  logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_in,
  output logic                           reg_req_out,
  output logic                           reg_ack_out,
  output logic                           reg_rd_wr_L_out,
  output logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out,
  output logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_out,
  input  logic [NUM_COUNTERS-1:0]        counter_inc,
  output logic [NUM_SW*32-1:0]           sw_regs
);

  logic [TAG_WIDTH-1:0]      tag;
  logic [REG_ADDR_WIDTH-1:0] idx;
  logic                      claim;
  logic                      claim_rd;
  logic                      claim_wr;
  logic [31:0]               counter_value [NUM_COUNTERS];
  logic [31:0]               sw_reg        [NUM_SW];
  logic [31:0]               rd_value;
  node_action_e              action;

  assign tag      = TAG_WIDTH'(addr_tag(reg_addr_in, TAG_WIDTH));
  assign idx      = REG_ADDR_WIDTH'(addr_index(reg_addr_in, REG_ADDR_WIDTH));
  assign claim    = reg_req_in && !reg_ack_in && (tag == TAG_WIDTH'(TAG));
  assign claim_rd = claim && reg_rd_wr_L_in;
  assign claim_wr = claim && !reg_rd_wr_L_in;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_COUNTERS; gi++) begin : g_counter
      logic hit;
      assign hit = (idx == REG_ADDR_WIDTH'(gi));
      udp_reg_event_counter u_counter (
        .clk        (clk),
        .reset      (reset),
        .inc        (counter_inc[gi]),
        .load       (claim_wr && hit),
        .load_value (reg_data_in),
        .rd_clear   (RESET_ON_READ && claim_rd && hit),
        .count      (counter_value[gi])
      );
    end

    for (gi = 0; gi < NUM_SW; gi++) begin : g_sw_reg
      logic [31:0] sw_reg_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          sw_reg_reg <= '0;
        end else if (claim_wr && idx == REG_ADDR_WIDTH'(NUM_COUNTERS + gi)) begin
          sw_reg_reg <= reg_data_in;
        end
      end
      assign sw_reg[gi]             = sw_reg_reg;
      assign sw_regs[gi*32 +: 32]   = sw_reg_reg;
    end
  endgenerate

  // Read data reflects register contents before this cycle's update.
  always_comb begin
    rd_value = UNDECODED_RESULT;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (idx == REG_ADDR_WIDTH'(i)) rd_value = counter_value[i];
    end
    for (int i = 0; i < NUM_SW; i++) begin
      if (idx == REG_ADDR_WIDTH'(NUM_COUNTERS + i)) rd_value = sw_reg[i];
    end
  end

  always_comb begin
    action = ACT_IDLE;
    if (claim)           action = ACT_CLAIM;
    else if (reg_req_in) action = ACT_FORWARD;
  end

  logic                           req_reg,  req_next;
  logic                           ack_reg,  ack_next;
  logic                           rw_reg,   rw_next;
  logic [UDP_REG_ADDR_WIDTH-1:0]  addr_reg, addr_next;
  logic [CPCI_NF2_DATA_WIDTH-1:0] data_reg, data_next;
  logic [UDP_REG_SRC_WIDTH-1:0]   src_reg,  src_next;

  always_comb begin
    req_next  = 1'b0;
    ack_next  = 1'b0;
    rw_next   = 1'b0;
    addr_next = '0;
    data_next = '0;
    src_next  = '0;
    case (action)
      ACT_FORWARD: begin
        req_next  = reg_req_in;
        ack_next  = reg_ack_in;
        rw_next   = reg_rd_wr_L_in;
        addr_next = reg_addr_in;
        data_next = reg_data_in;
        src_next  = reg_src_in;
      end
      ACT_CLAIM: begin
        req_next  = 1'b1;
        ack_next  = 1'b1;
        rw_next   = reg_rd_wr_L_in;
        addr_next = reg_addr_in;
        data_next = reg_rd_wr_L_in ? rd_value : reg_data_in;
        src_next  = reg_src_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_reg  <= 1'b0;
      ack_reg  <= 1'b0;
      rw_reg   <= 1'b0;
      addr_reg <= '0;
      data_reg <= '0;
      src_reg  <= '0;
    end else begin
      req_reg  <= req_next;
      ack_reg  <= ack_next;
      rw_reg   <= rw_next;
      addr_reg <= addr_next;
      data_reg <= data_next;
      src_reg  <= src_next;
    end
  end

  assign reg_req_out     = req_reg;
  assign reg_ack_out     = ack_reg;
  assign reg_rd_wr_L_out = rw_reg;
  assign reg_addr_out    = addr_reg;
  assign reg_data_out    = data_reg;
  assign reg_src_out     = src_reg;

endmodule

// File: tb/tb_udp_reg_counter_node.sv
// Bench: two node instances (plain and clear-on-read) driven in lockstep against an array-based ring model.
module tb_udp_reg_counter_node;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, ack, rw;
  logic [22:0] addr;
  logic [31:0] data;
  logic [1:0]  src;
  logic [3:0]  inc;

  logic        req_o  [2];
  logic        ack_o  [2];
  logic        rw_o   [2];
  logic [22:0] addr_o [2];
  logic [31:0] data_o [2];
  logic [1:0]  src_o  [2];
  logic [63:0] sw_o   [2];

  logic [31:0] m_cnt [2][4];
  logic [31:0] m_sw  [2][2];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  udp_reg_counter_node #(.RESET_ON_READ(1'b0)) dut0 (
    .clk(clk), .reset(reset),
    .reg_req_in(req), .reg_ack_in(ack), .reg_rd_wr_L_in(rw),
    .reg_addr_in(addr), .reg_data_in(data), .reg_src_in(src),
    .reg_req_out(req_o[0]), .reg_ack_out(ack_o[0]), .reg_rd_wr_L_out(rw_o[0]),
    .reg_addr_out(addr_o[0]), .reg_data_out(data_o[0]), .reg_src_out(src_o[0]),
    .counter_inc(inc), .sw_regs(sw_o[0])
  );

  udp_reg_counter_node #(.RESET_ON_READ(1'b1)) dut1 (
    .clk(clk), .reset(reset),
    .reg_req_in(req), .reg_ack_in(ack), .reg_rd_wr_L_in(rw),
    .reg_addr_in(addr), .reg_data_in(data), .reg_src_in(src),
    .reg_req_out(req_o[1]), .reg_ack_out(ack_o[1]), .reg_rd_wr_L_out(rw_o[1]),
    .reg_addr_out(addr_o[1]), .reg_data_out(data_o[1]), .reg_src_out(src_o[1]),
    .counter_inc(inc), .sw_regs(sw_o[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock: predict outputs from the current inputs, then compare both instances.
  task automatic cycle();
    logic [31:0] e_data [2];
    logic [31:0] rv;
    logic        claim;
    logic [5:0]  idx;
    logic [60:0] e_bus;
    idx   = addr[5:0];
    claim = req && !ack && (addr[22:6] == 17'd0);
    for (int d = 0; d < 2; d++) begin
      if (idx < 6'd4)      rv = m_cnt[d][idx];
      else if (idx < 6'd6) rv = m_sw[d][idx - 6'd4];
      else                 rv = 32'hdead_beef;
      e_data[d] = !req ? 32'd0 : (claim && rw) ? rv : data;
      for (int i = 0; i < 4; i++) begin
        if (reset)                              m_cnt[d][i] = 32'd0;
        else if (claim && !rw && idx == 6'(i))  m_cnt[d][i] = data;
        else if (d == 1 && claim && rw && idx == 6'(i)) m_cnt[d][i] = {31'd0, inc[i]};
        else                                    m_cnt[d][i] = m_cnt[d][i] + 32'(inc[i]);
      end
      for (int j = 0; j < 2; j++) begin
        if (reset)                                  m_sw[d][j] = 32'd0;
        else if (claim && !rw && idx == 6'(4 + j))  m_sw[d][j] = data;
      end
    end
    if (req) $display("xact t=%0t rst=%b ack=%b rw=%b addr=%h data=%h src=%0d inc=%b",
                      $time, reset, ack, rw, addr, data, src, inc);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (reset || !req) e_bus = '0;
      else               e_bus = {1'b1, claim ? 1'b1 : ack, rw, addr, e_data[d], src};
      check($sformatf("ring%0d", d),
            64'({req_o[d], ack_o[d], rw_o[d], addr_o[d], data_o[d], src_o[d]}), 64'(e_bus));
      check($sformatf("sw_regs%0d", d), sw_o[d], {m_sw[d][1], m_sw[d][0]});
    end
  endtask

  task automatic access(input logic r, input logic [22:0] a, input logic [31:0] dv,
                        input logic ak, input logic [3:0] ev);
    req = 1'b1; ack = ak; rw = r; addr = a; data = dv; src = 2'(a[1:0]); inc = ev;
    cycle();
    req = 1'b0; ack = 1'b0; rw = 1'b0; addr = '0; data = '0; src = '0; inc = '0;
  endtask

  task automatic idle(input int n, input logic [3:0] ev);
    for (int k = 0; k < n; k++) begin
      inc = ev;
      cycle();
    end
    inc = '0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) m_cnt[d][i] = '0;
      for (int j = 0; j < 2; j++) m_sw[d][j] = '0;
    end
    reset = 1'b1; req = 0; ack = 0; rw = 0; addr = '0; data = '0; src = '0; inc = '0;
    idle(2, 4'b0000);
    reset = 1'b0;
    idle(1, 4'b0000);

    // Five events on counter 2, then read it
    idle(5, 4'b0100);
    access(1'b1, 23'd2, 32'h0, 1'b0, 4'b0000);
    check("cnt2_five", 64'(data_o[0]), 64'd5);

    // Software register write then read-back
    access(1'b0, 23'd4, 32'h1234_5678, 1'b0, 4'b0000);
    check("sw0_port", 64'(sw_o[0][31:0]), 64'h1234_5678);
    access(1'b1, 23'd4, 32'h0, 1'b0, 4'b0000);
    check("sw0_read", 64'(data_o[0]), 64'h1234_5678);

    // Foreign tag and pre-acked traffic pass through untouched
    access(1'b0, {17'h1, 6'd4}, 32'h5555_aaaa, 1'b0, 4'b0000);
    access(1'b0, 23'd5, 32'h0000_cafe, 1'b1, 4'b0000);
    check("fwd_ack_data", 64'(data_o[0]), 64'h0000_cafe);
    access(1'b1, 23'd5, 32'h0, 1'b0, 4'b0000);

    // Wrap from near-full
    access(1'b0, 23'd1, 32'hffff_fffe, 1'b0, 4'b0000);
    idle(3, 4'b0010);
    access(1'b1, 23'd1, 32'h0, 1'b0, 4'b0000);
    check("cnt1_wrap", 64'(data_o[0]), 64'd1);

    // Clear-on-read with a coincident event
    access(1'b0, 23'd3, 32'd7, 1'b0, 4'b0000);
    access(1'b1, 23'd3, 32'h0, 1'b0, 4'b1000);
    check("ror_first", 64'(data_o[1]), 64'd7);
    access(1'b1, 23'd3, 32'h0, 1'b0, 4'b0000);
    check("ror_second", 64'(data_o[1]), 64'd1);
    check("nor_second", 64'(data_o[0]), 64'd8);

    // Write wins over a same-cycle event
    access(1'b0, 23'd0, 32'h0bad_f00d, 1'b0, 4'b0001);
    access(1'b1, 23'd0, 32'h0, 1'b0, 4'b0000);
    check("write_wins", 64'(data_o[0]), 64'h0bad_f00d);

    // Undecoded index
    access(1'b1, 23'd40, 32'h0, 1'b0, 4'b0000);
    check("undecoded", 64'(data_o[0]), 64'hdead_beef);
    check("undecoded_ack", 64'(ack_o[0]), 64'd1);

    // Reset during a read
    reset = 1'b1;
    access(1'b1, 23'd2, 32'h0, 1'b0, 4'b0000);
    reset = 1'b0;
    access(1'b1, 23'd2, 32'h0, 1'b0, 4'b0000);
    check("cnt2_after_reset", 64'(data_o[0]), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      req   = ($urandom_range(0, 3) != 0);
      ack   = ($urandom_range(0, 7) == 0);
      rw    = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 5))
        0:       addr = 23'($urandom);
        1:       addr = 23'($urandom_range(0, 63));
        default: addr = 23'($urandom_range(0, 7));
      endcase
      data  = ($urandom_range(0, 7) == 0) ? 32'hffff_fffd : $urandom;
      src   = 2'($urandom);
      inc   = 4'($urandom);
      reset = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset = 1'b0; req = 1'b0; inc = '0;
    idle(1, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/udp_reg_counter_node.md
Name: udp_reg_counter_node

Overview:
- Slave node on the UDP register ring, directly downstream of the ring master.
- Consumes the master's request bus and claims accesses whose address tag matches its block.
- Services those accesses from a bank of hardware event counters and software read/write registers, then drives the ring onward toward the master's return input.
- Non-matching or already-acked transactions pass through unchanged with one cycle of latency.

Parameters:
- TAG, 'h0, block address tag compared against the upper address bits.
- TAG_WIDTH, 17, width of the tag field: reg_addr_in[UDP_REG_ADDR_WIDTH-1 -: TAG_WIDTH].
- REG_ADDR_WIDTH, 6, width of the in-block index field: reg_addr_in[REG_ADDR_WIDTH-1:0]. TAG_WIDTH+REG_ADDR_WIDTH = UDP_REG_ADDR_WIDTH.
- NUM_COUNTERS, 4, number of 32-bit event counters, at indices 0..NUM_COUNTERS-1.
- NUM_SW, 2, number of 32-bit software registers, at indices NUM_COUNTERS..NUM_COUNTERS+NUM_SW-1.
- RESET_ON_READ, 0, when 1 a counter read clears that counter.
- UDP_REG_SRC_WIDTH, 2, width of the source field.
- UNDECODED_RESULT, 'hdead_beef, read data returned for an in-tag index beyond the map.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- reg_req_in  in  1  ring request valid.
- reg_ack_in  in  1  ring request already acknowledged upstream.
- reg_rd_wr_L_in  in  1  1=read, 0=write.
- reg_addr_in  in  UDP_REG_ADDR_WIDTH  word address.
- reg_data_in  in  CPCI_NF2_DATA_WIDTH  write data / upstream read result.
- reg_src_in  in  UDP_REG_SRC_WIDTH  requester id.
- reg_req_out, reg_ack_out, reg_rd_wr_L_out  out  1 each  registered ring outputs.
- reg_addr_out  out  UDP_REG_ADDR_WIDTH  registered.
- reg_data_out  out  CPCI_NF2_DATA_WIDTH  registered.
- reg_src_out  out  UDP_REG_SRC_WIDTH  registered.
- counter_inc  in  NUM_COUNTERS  per-counter +1 strobe, one increment per cycle high.
- sw_regs  out  NUM_SW*32  software register values, index NUM_COUNTERS at bits [31:0].

Behaviour:
- Reset: all ring outputs 0, all counters 0, sw_regs 0.
- Ring outputs always change exactly 1 cycle after the inputs. No stall, no backpressure.
- claim = reg_req_in && !reg_ack_in && tag==TAG.
- Forward case (reg_req_in && !claim): copy all six inputs to the outputs.
- Claim case:
  - req_out=1, ack_out=1; rd_wr_L, addr and src copied.
  - Read: data_out = selected register value before this cycle's update.
  - Write: data_out = reg_data_in; target register loads reg_data_in.
  - Index beyond the map: reads return UNDECODED_RESULT; writes are dropped, ack still asserted.
- Idle case (!reg_req_in): all outputs 0.
- Counters are unsigned 32-bit and wrap from 'hffff_ffff to 0.
- Write to a counter loads the written value; a concurrent counter_inc is ignored for that cycle (write wins).
- RESET_ON_READ=1: read returns the pre-read value. The counter becomes 1 if counter_inc is high that cycle, else 0.
- RESET_ON_READ=0: a read has no side effect.
- Software registers are RW and held until written or reset.
- reset asserted mid-transaction: the in-flight cycle is discarded and outputs are 0 on the next cycle.

Decomposition:
- Shared package/include holds: UDP_REG_ADDR_WIDTH and CPCI_NF2_DATA_WIDTH (existing defines), UNDECODED_RESULT, and the tag/index split macros.
- One sub-module, udp_reg_event_counter: a single 32-bit counter with inc, load, clear-on-read and wrap. Instantiated NUM_COUNTERS times via generate.

Test Plan:
- Read counter 2 after 5 strobes on counter_inc[2] (tag match, idx 2) -> 1 cycle later req_out=1, ack_out=1, data_out=5.
- Write 'h1234_5678 to idx 4 (sw reg 0), then read it -> sw_regs[31:0]='h1234_5678 after the write cycle; read returns 'h1234_5678.
- Request with tag≠TAG, or with reg_ack_in=1 and data 'hcafe -> outputs are an exact copy of the inputs 1 cycle later; no register changes.
- Counter preloaded via write to 'hffff_fffe, then 3 strobes -> read returns 1 (wrap).
- RESET_ON_READ=1, counter=7, read with counter_inc high in the same cycle -> data_out=7, next read returns 1. Write to idx 0 with counter_inc[0] high -> counter equals the written value.
- Read idx 40 within tag -> ack_out=1, data_out='hdead_beef. Assert reset mid-read -> outputs 0 next cycle and counters 0.
